// File: rtl/cic_pkg.sv
// Shared constants and width helper for the CIC decimator.
package cic_pkg;

    localparam int MAX_STAGES     = 6;
    localparam int MAX_DECIM_LOG2 = 6;

    // Bit growth of an N-stage CIC with ratio 2^dlog2 is N*dlog2 bits on top of the input.
    function automatic int cic_width(input int in_w, input int stages, input int dlog2);
        return in_w + stages * dlog2;
    endfunction

endpackage

// File: rtl/cic_decimator_if.sv
// Sample stream in / decimated stream out for the CIC decimator.
interface cic_decimator_if #(
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = 16
);
    logic                 i_stb;
    logic [IN_WIDTH-1:0]  i_data;
    logic                 o_stb;
    logic [OUT_WIDTH-1:0] o_data;

    modport master (
        output i_stb,
        output i_data,
        input  o_stb,
        input  o_data
    );

    modport slave (
        input  i_stb,
        input  i_data,
        output o_stb,
        output o_data
    );
endinterface

// File: rtl/cic_comb_stage.sv
// One comb section: differential delay of one decimated sample, updated on dec_stb.
module cic_comb_stage #(
    parameter int W = 21
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [W-1:0] i_x,
    output logic [W-1:0] o_c
);
    logic [W-1:0] dly_q;
    logic [W-1:0] dly_d;

    always_comb begin
        dly_d = dly_q;
        if (i_en) begin
            dly_d = i_x;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dly_q <= '0;
        end else begin
            dly_q <= dly_d;
        end
    end

    assign o_c = i_x - dly_q;
endmodule

// File: rtl/cic_decimator.sv
// Decimating CIC filter: integrators at the input strobe rate, combs at the decimated rate.
module cic_decimator
    import cic_pkg::*;
#(
    parameter int IN_WIDTH   = 12,
    parameter int STAGES     = 3,
    parameter int DECIM_LOG2 = 3,
    parameter int OUT_WIDTH  = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    cic_decimator_if.slave bus
);
    localparam int W = cic_width(IN_WIDTH, STAGES, DECIM_LOG2);

    generate
        if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
            $error("cic_decimator: STAGES out of range");
        end
        if (DECIM_LOG2 < 1 || DECIM_LOG2 > MAX_DECIM_LOG2) begin : g_bad_decim
            $error("cic_decimator: DECIM_LOG2 out of range");
        end
        if (OUT_WIDTH > W || OUT_WIDTH < 1) begin : g_bad_out
            $error("cic_decimator: OUT_WIDTH exceeds internal width");
        end
    endgenerate

    logic [W-1:0]          int_q [STAGES];
    logic [W-1:0]          int_d [STAGES];
    logic [DECIM_LOG2-1:0] phase_q;
    logic [DECIM_LOG2-1:0] phase_d;
    logic                  dec_stb_q;
    logic                  dec_stb_d;
    logic                  o_stb_q;
    logic                  o_stb_d;
    logic [OUT_WIDTH-1:0]  o_data_q;
    logic [OUT_WIDTH-1:0]  o_data_d;
    logic [W-1:0]          in_sext;
    logic [W-1:0]          chain [STAGES+1];

    assign in_sext = {{(W-IN_WIDTH){bus.i_data[IN_WIDTH-1]}}, bus.i_data};

    // Each integrator adds the previous-cycle value of the one before it; wrap is intended.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            int_d[k] = int_q[k];
        end
        phase_d   = phase_q;
        dec_stb_d = 1'b0;
        if (bus.i_stb) begin
            int_d[0] = int_q[0] + in_sext;
            for (int k = 1; k < STAGES; k++) begin
                int_d[k] = int_q[k] + int_q[k-1];
            end
            phase_d   = phase_q + DECIM_LOG2'(1);
            dec_stb_d = (phase_q == {DECIM_LOG2{1'b1}});
        end
    end

    assign chain[0] = int_q[STAGES-1];

    generate
        for (genvar g = 0; g < STAGES; g++) begin : g_comb
            cic_comb_stage #(
                .W(W)
            ) u_comb (
                .i_clk (i_clk),
                .i_rst (i_rst),
                .i_en  (dec_stb_q),
                .i_x   (chain[g]),
                .o_c   (chain[g+1])
            );
        end
    endgenerate

    always_comb begin
        o_stb_d  = dec_stb_q;
        o_data_d = o_data_q;
        if (dec_stb_q) begin
            o_data_d = chain[STAGES][W-1 -: OUT_WIDTH];
        end
    end

    // Truncated LSBs are dropped by design, not rounded.
    generate
        if (W > OUT_WIDTH) begin : g_trunc
            logic unused_lsb;
            assign unused_lsb = ^chain[STAGES][W-OUT_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < STAGES; k++) begin
                int_q[k] <= '0;
            end
            phase_q   <= '0;
            dec_stb_q <= 1'b0;
            o_stb_q   <= 1'b0;
            o_data_q  <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                int_q[k] <= int_d[k];
            end
            phase_q   <= phase_d;
            dec_stb_q <= dec_stb_d;
            o_stb_q   <= o_stb_d;
            o_data_q  <= o_data_d;
        end
    end

    assign bus.o_stb  = o_stb_q;
    assign bus.o_data = o_data_q;
endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator against a strobe-level CIC reference model.
module tb_cic_decimator;
    localparam int IN_W  = 12;
    localparam int N     = 3;
    localparam int DL    = 3;
    localparam int OUT_W = 16;
    localparam int W     = IN_W + N * DL;
    localparam int R     = 1 << DL;
    localparam longint MASK = (longint'(1) << W) - 1;

    typedef struct {
        logic [OUT_W-1:0] data;
        int               cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   outs = 0;
    logic [OUT_W-1:0] last_o = '0;

    longint integ [N];
    longint dec_hist [$];
    int     nstb;
    exp_t   sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cic_decimator_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus ();

    cic_decimator #(
        .IN_WIDTH   (IN_W),
        .STAGES     (N),
        .DECIM_LOG2 (DL),
        .OUT_WIDTH  (OUT_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    function automatic longint binom(input int n, input int k);
        longint r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) integ[k] = 0;
        dec_hist.delete();
        sb.delete();
        nstb = 0;
        outs = 0;
    endtask

    // Integrator chain per strobe; comb chain as an N-th order difference of decimated values.
    task automatic model_strobe(input int x);
        longint acc;
        logic [63:0] tmp;
        exp_t e;
        int m;
        for (int k = N - 1; k >= 1; k--) integ[k] = (integ[k] + integ[k-1]) & MASK;
        integ[0] = (integ[0] + longint'(x)) & MASK;
        nstb++;
        if (nstb % R == 0) begin
            dec_hist.push_back(integ[N-1]);
            m = dec_hist.size() - 1;
            acc = 0;
            for (int i = 0; i <= N; i++) begin
                if (m - i >= 0) acc += ((i % 2) ? -1 : 1) * binom(N, i) * dec_hist[m-i];
            end
            tmp = 64'((acc & MASK) >> (W - OUT_W));
            e.data = tmp[OUT_W-1:0];
            e.cyc  = cyc + 2;
            sb.push_back(e);
        end
    endtask

    task automatic drive(input bit stb, input int x);
        @(negedge clk);
        bus.i_stb  = stb;
        bus.i_data = x[IN_W-1:0];
        if (stb) model_strobe(x);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() > 0 && n < 30) begin
            drive(1'b0, 0);
            n++;
        end
        repeat (4) drive(1'b0, 0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d want=0", name, sb.size());
        end
        checks++;
        if (outs != nstb / R) begin
            errors++;
            $display("FAIL %s_count outputs=%0d want=%0d", name, outs, nstb / R);
        end
    endtask

    task automatic run_const(input string name, input int x, input int n, input int want);
        logic [OUT_W-1:0] w;
        w = want[OUT_W-1:0];
        repeat (n) drive(1'b1, x);
        drain(name);
        checks++;
        if (last_o !== w) begin
            errors++;
            $display("FAIL %s_steady got=%0d want=%0d", name, $signed(last_o), $signed(w));
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.o_stb === 1'b1) begin
                outs++;
                last_o = bus.o_data;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected cyc=%0d got=%0d want=no_output", cyc, $signed(bus.o_data));
                end else begin
                    e = sb.pop_front();
                    if (bus.o_data !== e.data || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL sb_data got=%0d@%0d want=%0d@%0d",
                                 $signed(bus.o_data), cyc, $signed(e.data), e.cyc);
                    end
                end
            end
        end
    end

    initial begin : stim
        int x;
        bit stb;
        rst        = 1'b1;
        bus.i_stb  = 1'b0;
        bus.i_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        checks += 2;
        if (bus.o_stb !== 1'b0) begin
            errors++;
            $display("FAIL reset_ostb got=%b want=0", bus.o_stb);
        end
        if (bus.o_data !== '0) begin
            errors++;
            $display("FAIL reset_odata got=%0d want=0", bus.o_data);
        end
        rst = 1'b0;

        repeat (3000) begin
            stb = ($urandom_range(0, 99) < 30);
            x   = int'($urandom_range(0, 4095)) - 2048;
            drive(stb, x);
        end
        drain("rand");

        run_const("neg_fs", -2048, 80, -32768);
        run_const("pos_fs_wrap", 2047, 4000, 32752);
        run_const("unit", 1, 80, 16);

        // Mid-group asynchronous reset: 5 strobes of a fresh group, then reset between edges.
        repeat (5) drive(1'b1, 300);
        #2;
        rst = 1'b1;
        #1;
        checks += 2;
        if (bus.o_stb !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_ostb got=%b want=0", bus.o_stb);
        end
        if (bus.o_data !== '0) begin
            errors++;
            $display("FAIL async_rst_odata got=%0d want=0", $signed(bus.o_data));
        end
        model_reset();
        bus.i_stb = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) drive(1'b1, 1000);
        repeat (12) drive(1'b0, 0);
        drain("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
